// File: rtl/req_gen4.sv
// req_gen4: four-channel requester feeding a 4-way rotating-priority arbiter.
//
// Each channel keeps a saturating pending-job counter; a nonzero count raises
// req[i]. While IDLE the arbiter is enabled (en=1). A legal one-hot grant moves
// the block to BUSY for SERVICE_CYCLES cycles with the arbiter disabled, and
// done[served_id] pulses in the last BUSY cycle. Illegal grants are ignored
// apart from setting the sticky err flag.
//
// Ports:
//   clock      in   1  rising-edge clock
//   reset      in   1  asynchronous active-high reset
//   job_valid  in   4  one new job per set bit per cycle
//   gnt        in   4  arbiter grant, expected one-hot or zero
//   req        out  4  channel has pending work
//   en         out  1  arbiter enable (high while IDLE)
//   done       out  4  one-cycle pulse on the served channel, last BUSY cycle
//   served_id  out  2  channel being served (holds its value while IDLE)
//   overflow   out  4  sticky, job dropped on a full counter
//   err        out  1  sticky, illegal grant observed
module req_gen4 #(
    parameter int unsigned SERVICE_CYCLES = 2,
    parameter int unsigned CNT_W          = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] job_valid,
    input  logic [3:0] gnt,
    output logic [3:0] req,
    output logic       en,
    output logic [3:0] done,
    output logic [1:0] served_id,
    output logic [3:0] overflow,
    output logic       err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       BUSY_LOAD = 4'(SERVICE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [3:0]       busy_cnt, busy_cnt_nxt;
    logic [1:0]       served_id_nxt;
    logic [CNT_W-1:0] pending     [4];
    logic [CNT_W-1:0] pending_nxt [4];
    logic [3:0]       overflow_nxt;
    logic             err_nxt;

    logic             gnt_onehot;
    logic             gnt_legal;
    logic [1:0]       gnt_idx;

    // Outputs are decoded from registers only, so req -> gnt -> here never
    // closes a combinational loop through the arbiter.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            req[i] = (pending[i] != '0);
        end
        en   = (state == IDLE);
        done = (state == BUSY && busy_cnt == '0) ? (4'b0001 << served_id) : '0;
    end

    always_comb begin
        gnt_onehot = (gnt != '0) && ((gnt & (gnt - 4'd1)) == '0);
        // A grant is only honoured in IDLE and only on a requesting channel.
        gnt_legal  = (state == IDLE) && gnt_onehot && ((gnt & ~req) == '0);
        gnt_idx    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (gnt[i]) begin
                gnt_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        busy_cnt_nxt  = busy_cnt;
        served_id_nxt = served_id;
        err_nxt       = err | ((gnt != '0) && !gnt_legal);

        case (state)
            IDLE: begin
                if (gnt_legal) begin
                    state_nxt     = BUSY;
                    served_id_nxt = gnt_idx;
                    busy_cnt_nxt  = BUSY_LOAD;
                end
            end
            BUSY: begin
                if (busy_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    busy_cnt_nxt = busy_cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        overflow_nxt = overflow;
        for (int unsigned i = 0; i < 4; i++) begin
            pending_nxt[i] = pending[i];
            if (job_valid[i] && !(gnt_legal && gnt[i])) begin
                if (pending[i] == CNT_MAX) begin
                    overflow_nxt[i] = 1'b1;
                end else begin
                    pending_nxt[i] = pending[i] + CNT_W'(1);
                end
            end else if (!job_valid[i] && gnt_legal && gnt[i]) begin
                pending_nxt[i] = pending[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            served_id <= '0;
            overflow  <= '0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                pending[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            busy_cnt  <= busy_cnt_nxt;
            served_id <= served_id_nxt;
            overflow  <= overflow_nxt;
            err       <= err_nxt;
            for (int unsigned i = 0; i < 4; i++) begin
                pending[i] <= pending_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_req_gen4.sv
// tb_req_gen4: self-checking bench for req_gen4.
//
// A behavioural model (job counts as integers, remaining BUSY cycles counted
// down from SERVICE_CYCLES) predicts every output each cycle. Directed steps
// cover reset, single-job timing, overflow, illegal grants and a closed loop
// with a rotating arbiter; a randomized phase follows.
module tb_req_gen4;

    localparam int SC    = 2;
    localparam int CW    = 2;
    localparam int MAXP  = (1 << CW) - 1;

    logic       clock;
    logic       reset;
    logic [3:0] job_valid;
    logic [3:0] gnt;
    logic [3:0] req;
    logic       en;
    logic [3:0] done;
    logic [1:0] served_id;
    logic [3:0] overflow;
    logic       err;

    req_gen4 #(
        .SERVICE_CYCLES(SC),
        .CNT_W         (CW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .job_valid(job_valid),
        .gnt      (gnt),
        .req      (req),
        .en       (en),
        .done     (done),
        .served_id(served_id),
        .overflow (overflow),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int         m_pend [4];
    int         m_rem;      // BUSY cycles left including the current one; 0 = idle
    int         m_served;
    logic [3:0] m_ovf;
    logic       m_err;

    int         arb_ptr;
    int         cyc;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (m_pend[i] != 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 0;
        m_rem    = 0;
        m_served = 0;
        m_ovf    = '0;
        m_err    = 1'b0;
    endtask

    task automatic model_check();
        logic [3:0] exp_done;
        exp_done = (m_rem == 1) ? (4'b0001 << m_served) : 4'b0000;
        chk("req",       8'(req),       8'(m_req()));
        chk("en",        8'(en),        8'(m_rem == 0));
        chk("done",      8'(done),      8'(exp_done));
        chk("served_id", 8'(served_id), 8'(m_served));
        chk("overflow",  8'(overflow),  8'(m_ovf));
        chk("err",       8'(err),       8'(m_err));
    endtask

    task automatic model_update(input logic [3:0] jv, input logic [3:0] g);
        logic [3:0] r;
        logic       idle;
        logic       legal;
        int         idx;
        r     = m_req();
        idle  = (m_rem == 0);
        legal = idle && ($countones(g) == 1) && ((g & r) == g);
        idx   = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        if (g != 0 && !legal) m_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (jv[i] && !(legal && g[i])) begin
                if (m_pend[i] == MAXP) m_ovf[i] = 1'b1;
                else m_pend[i]++;
            end else if (!jv[i] && legal && g[i]) begin
                m_pend[i]--;
            end
        end
        if (!idle) m_rem--;
        else if (legal) begin
            m_rem    = SC;
            m_served = idx;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [3:0] jv, input logic [3:0] g);
        job_valid = jv;
        gnt       = g;
        model_check();
        @(posedge clock);
        model_update(jv, g);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        job_valid = '0;
        gnt       = '0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [3:0] arb(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (ptr + k) % 4;
            if (r[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    // Rotating arbiter driven from the DUT's registered req/en.
    task automatic arb_step(input logic [3:0] jv);
        logic [3:0] g;
        g = en ? arb(req, arb_ptr) : 4'b0000;
        for (int i = 0; i < 4; i++) if (g[i]) arb_ptr = (i + 1) % 4;
        step(jv, g);
    endtask

    initial begin
        int done_cnt [4];
        int last_done;
        logic [3:0] jv;
        logic [3:0] g;

        cyc       = 0;
        arb_ptr   = 0;
        reset     = 1'b1;
        job_valid = '0;
        gnt       = '0;
        model_reset();
        @(negedge clock);
        chk("rst_req", 8'(req), 8'h0);
        chk("rst_en", 8'(en), 8'h1);
        chk("rst_done", 8'(done), 8'h0);
        chk("rst_sid", 8'(served_id), 8'h0);
        chk("rst_ovf", 8'(overflow), 8'h0);
        chk("rst_err", 8'(err), 8'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Single job on ch0
        step(4'b0001, 4'b0000);                 // t0
        chk("single_req_t1", 8'(req), 8'h1);
        step(4'b0000, 4'b0001);                 // t1 grant
        chk("single_en_t2", 8'(en), 8'h0);
        step(4'b0000, 4'b0000);                 // t2
        chk("single_en_t3", 8'(en), 8'h0);
        chk("single_done_t3", 8'(done), 8'h1);
        step(4'b0000, 4'b0000);                 // t3
        chk("single_req_t4", 8'(req), 8'h0);
        chk("single_en_t4", 8'(en), 8'h1);

        // Overflow on ch2 then simultaneous inc/dec
        for (int k = 0; k < 4; k++) step(4'b0100, 4'b0000);
        chk("ovf_flag", 8'(overflow), 8'h4);
        step(4'b0100, 4'b0100);
        for (int k = 0; k < SC; k++) step(4'b0000, 4'b0000);
        chk("incdec_req", 8'(req), 8'h4);
        for (int k = 0; k < 12; k++) arb_step(4'b0000);
        chk("drain_req", 8'(req), 8'h0);

        // Reset in the done cycle of BUSY with ch1 pending=2
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0010, 4'b0000);
        step(4'b0000, 4'b0010);
        step(4'b0000, 4'b0000);
        reset = 1'b1;
        #1;
        chk("midrst_req", 8'(req), 8'h0);
        chk("midrst_en", 8'(en), 8'h1);
        chk("midrst_done", 8'(done), 8'h0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(4'b0000, 4'b0000);

        // Multi-bit grant
        step(4'b0011, 4'b0000);
        step(4'b0000, 4'b0011);
        chk("ill_multi_err", 8'(err), 8'h1);
        chk("ill_multi_en", 8'(en), 8'h1);
        chk("ill_multi_req", 8'(req), 8'h3);

        // Grant on a non-requesting channel
        do_reset();
        step(4'b0000, 4'b1000);
        chk("ill_noreq_err", 8'(err), 8'h1);

        // Grant during BUSY must not shorten the window
        do_reset();
        step(4'b0011, 4'b0000);
        step(4'b0000, 4'b0001);
        step(4'b0000, 4'b0001);
        chk("ill_busy_err", 8'(err), 8'h1);
        chk("ill_busy_en", 8'(en), 8'h0);
        chk("ill_busy_done", 8'(done), 8'h1);
        step(4'b0000, 4'b0000);
        chk("ill_busy_idle", 8'(en), 8'h1);

        // Closed loop: 3 jobs per channel, rotating arbiter
        do_reset();
        arb_ptr = 0;
        for (int k = 0; k < 3; k++) step(4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        last_done = -100;
        for (int k = 0; k < 80; k++) begin
            if (done != 0) begin
                chk("loop_spacing", 8'(cyc - last_done >= SC + 1), 8'h1);
                last_done = cyc;
                for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
            end
            arb_step(4'b0000);
        end
        for (int i = 0; i < 4; i++) chk("loop_done_cnt", 8'(done_cnt[i]), 8'h3);
        chk("loop_err", 8'(err), 8'h0);

        // Randomized traffic with occasional illegal grants
        do_reset();
        for (int k = 0; k < 400; k++) begin
            jv = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                g = 4'($urandom);
                step(jv, g);
            end else begin
                arb_step(jv);
            end
        end
        step(4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
